// File: rtl/hs_parallel_pkg.sv
// Shared definitions for the handshake parallel input/output interfaces.
package hs_parallel_pkg;

  // Output handshake states
  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_SETUP    = 2'b01,
    S_WAIT_ACK = 2'b10,
    S_RELEASE  = 2'b11
  } state_e;

  // Status register bit positions
  localparam int unsigned ST_FO    = 0;
  localparam int unsigned ST_EMPTY = 1;
  localparam int unsigned ST_OVR   = 2;

  // a0 register select codes, shared with the input interface
  localparam logic A0_DATA   = 1'b0;
  localparam logic A0_STATUS = 1'b1;

endpackage

// File: rtl/hs_parallel_out_if.sv
// Processor strobes plus consumer handshake of the parallel output port.
interface hs_parallel_out_if;
  logic       s_;
  logic       ior_;
  logic       iow_;
  logic       a0;
  logic       dav_;
  logic       rfd;
  logic [7:0] byte_out;

  // master: processor + consumer side; slave: the output interface block
  modport master (output s_, ior_, iow_, a0, rfd, input dav_, byte_out);
  modport slave  (input s_, ior_, iow_, a0, rfd, output dav_, byte_out);
endinterface

// File: rtl/hs_out_fifo.sv
// DEPTH x 8 byte FIFO with synchronous push/pop and wrapping pointers.
module hs_out_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic       clock,
  input  logic       reset_,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign head    = mem[rptr_q];
  // Guard against pushing into a full or popping an empty buffer
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointer and occupancy update; simultaneous push/pop keeps count
  always_ff @(posedge clock) begin
    if (!reset_) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are don't-care while empty, so no reset
  always_ff @(posedge clock) begin
    if (do_push) mem[wptr_q] <= wdata;
  end

endmodule

// File: rtl/hs_parallel_out.sv
// Handshake parallel output interface: bus-written bytes are buffered and
// delivered to a consumer with the dav_/rfd handshake.
module hs_parallel_out
  import hs_parallel_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic             clock,
  input  logic             reset_,
  hs_parallel_out_if.slave bus,
  inout  wire  [7:0]       d7_d0
);

  logic       illegal, wr, rd_any, rd_st;
  logic       wr_q, rd_q, wr_fire, rd_fire;
  logic       push, pop, overflow;
  logic       fifo_full, fifo_empty;
  logic       ovr_q, dav_q;
  logic [7:0] head, status, rd_data, byte_out_q;
  state_e     state_q;

  // Bus decode; both strobes low is illegal and neither reads nor writes
  assign illegal = ~bus.ior_ & ~bus.iow_;
  assign wr      = ~bus.s_ & ~bus.iow_ & (bus.a0 == A0_DATA) & ~illegal;
  assign rd_any  = ~bus.s_ & ~bus.ior_ & ~illegal;
  assign rd_st   = rd_any & (bus.a0 == A0_STATUS);

  // Only the first edge of a held strobe counts
  assign wr_fire  = wr & ~wr_q;
  assign rd_fire  = rd_st & ~rd_q;
  assign overflow = wr_fire & fifo_full;
  assign push     = wr_fire & ~fifo_full;
  assign pop      = (state_q == S_WAIT_ACK) & ~bus.rfd;

  // Status register image
  always_comb begin
    status           = '0;
    status[ST_FO]    = ~fifo_full;
    status[ST_EMPTY] = fifo_empty & (state_q == S_IDLE);
    status[ST_OVR]   = ovr_q;
  end

  assign rd_data      = (bus.a0 == A0_STATUS) ? status : 8'h00;
  assign d7_d0        = rd_any ? rd_data : 8'hzz;
  assign bus.dav_     = dav_q;
  assign bus.byte_out = byte_out_q;

  hs_out_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clock (clock),
    .reset_(reset_),
    .push  (push),
    .pop   (pop),
    .wdata (d7_d0),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Strobe level history for the write/status-read edge detectors
  always_ff @(posedge clock) begin
    if (!reset_) begin
      wr_q <= 1'b0;
      rd_q <= 1'b0;
    end else begin
      wr_q <= wr;
      rd_q <= rd_st;
    end
  end

  // Sticky overrun flag; an overflow wins over a clearing status read
  always_ff @(posedge clock) begin
    if (!reset_) begin
      ovr_q <= 1'b0;
    end else if (overflow) begin
      ovr_q <= 1'b1;
    end else if (rd_fire) begin
      ovr_q <= 1'b0;
    end
  end

  // Consumer handshake: latch byte, one setup cycle, wait ack, wait release
  always_ff @(posedge clock) begin
    if (!reset_) begin
      state_q    <= S_IDLE;
      dav_q      <= 1'b1;
      byte_out_q <= 8'h00;
    end else begin
      case (state_q)
        S_IDLE: begin
          dav_q <= 1'b1;
          if (!fifo_empty && bus.rfd) begin
            byte_out_q <= head;
            state_q    <= S_SETUP;
          end
        end
        S_SETUP: begin
          dav_q   <= 1'b0;
          state_q <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (!bus.rfd) begin
            dav_q   <= 1'b1;
            state_q <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          dav_q <= 1'b1;
          if (bus.rfd) state_q <= S_IDLE;
        end
        default: begin
          dav_q   <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hs_parallel_out.sv
// Self-checking bench for hs_parallel_out: directed scenarios plus a
// randomized run against a queue-based model of the buffer.
module tb_hs_parallel_out;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;

  logic       clock = 1'b0;
  logic       reset_;
  wire  [7:0] d7_d0;
  logic       tb_drive;
  logic [7:0] tb_data;

  hs_parallel_out_if bus ();

  assign d7_d0 = tb_drive ? tb_data : 8'hzz;

  hs_parallel_out #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) dut (
    .clock (clock),
    .reset_(reset_),
    .bus   (bus),
    .d7_d0 (d7_d0)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model: buffered bytes, overrun flag, strobe history
  logic [7:0] q[$];
  logic       m_ovr = 1'b0;
  logic       m_wr_prev = 1'b0;
  logic       m_rd_prev = 1'b0;

  // Consumer model state
  logic cons_auto = 1'b0;
  logic c_wait = 1'b0;
  int   c_low = 0;

  // Bytes seen at each falling edge of dav_
  logic [7:0] seen[$];
  logic       dav_prev = 1'b1;

  always @(negedge clock) begin
    if (dav_prev === 1'b1 && bus.dav_ === 1'b0) seen.push_back(bus.byte_out);
    dav_prev <= bus.dav_;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  // One clock: consumer reacts, model follows the edge, return at negedge
  task automatic tick();
    logic wr_now, rd_now, pop_now, full_pre, rst_now;
    logic [7:0] wdata;
    if (cons_auto) begin
      if (bus.rfd) begin
        if (bus.dav_ === 1'b0) begin
          if (c_wait) begin
            bus.rfd = 1'b0;
            c_low   = 3;
            c_wait  = 1'b0;
          end else begin
            c_wait = 1'b1;
          end
        end
      end else begin
        if (c_low > 0) c_low--;
        if (c_low == 0) bus.rfd = 1'b1;
      end
    end
    wr_now   = !bus.s_ && !bus.iow_ && bus.ior_ && !bus.a0;
    rd_now   = !bus.s_ && !bus.ior_ && bus.iow_ && bus.a0;
    pop_now  = (bus.dav_ === 1'b0) && (bus.rfd === 1'b0);
    full_pre = (q.size() == int'(DEPTH));
    rst_now  = (reset_ !== 1'b1);
    wdata    = tb_data;
    @(posedge clock);
    if (rst_now) begin
      q.delete();
      m_ovr     = 1'b0;
      m_wr_prev = 1'b0;
      m_rd_prev = 1'b0;
    end else begin
      if (pop_now && q.size() > 0) void'(q.pop_front());
      if (wr_now && !m_wr_prev) begin
        if (full_pre) m_ovr = 1'b1;
        else q.push_back(wdata);
      end
      if (rd_now && !m_rd_prev) m_ovr = 1'b0;
      m_wr_prev = wr_now;
      m_rd_prev = rd_now;
    end
    @(negedge clock);
  endtask

  task automatic write_byte(input logic [7:0] v);
    bus.s_ = 1'b0; bus.a0 = 1'b0; bus.iow_ = 1'b0;
    tb_data = v; tb_drive = 1'b1;
    tick();
    bus.s_ = 1'b1; bus.iow_ = 1'b1; tb_drive = 1'b0;
    tick();
  endtask

  task automatic read_status(input logic sel, output logic [7:0] v);
    bus.s_ = 1'b0; bus.a0 = sel; bus.ior_ = 1'b0;
    #1 v = d7_d0;
    tick();
    bus.s_ = 1'b1; bus.ior_ = 1'b1; bus.a0 = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [7:0] st;
    reset_ = 1'b0;
    bus.rfd = 1'b1;
    tick(); tick();
    reset_ = 1'b1;
    tick();
    checks++;
    if (bus.dav_ !== 1'b1) begin
      errors++; $display("FAIL reset_dav: got %b want 1", bus.dav_);
    end
    checks++;
    if (bus.byte_out !== 8'h00) begin
      errors++; $display("FAIL reset_byte_out: got %02h want 00", bus.byte_out);
    end
    read_status(1'b1, st);
    checks++;
    if (st !== 8'h03) begin
      errors++; $display("FAIL reset_status: got %02h want 03", st);
    end
  endtask

  task automatic test_single_transfer();
    logic [7:0] st;
    cons_auto = 1'b1; c_wait = 1'b0; c_low = 0; seen.delete();
    bus.s_ = 1'b0; bus.a0 = 1'b0; bus.iow_ = 1'b0; tb_data = 8'hA5; tb_drive = 1'b1;
    tick();  // edge N: write accepted
    bus.s_ = 1'b1; bus.iow_ = 1'b1; tb_drive = 1'b0;
    tick();  // N+1
    checks++;
    if (bus.byte_out !== 8'hA5 || bus.dav_ !== 1'b1) begin
      errors++; $display("FAIL single_n1: got byte %02h dav %b want A5 dav 1", bus.byte_out, bus.dav_);
    end
    tick();  // N+2
    checks++;
    if (bus.dav_ !== 1'b0) begin
      errors++; $display("FAIL single_n2_dav: got %b want 0", bus.dav_);
    end
    tick();  // N+3: consumer still holding rfd high
    checks++;
    if (bus.dav_ !== 1'b0) begin
      errors++; $display("FAIL single_n3_dav: got %b want 0", bus.dav_);
    end
    tick();  // N+4: rfd low at this edge
    checks++;
    if (bus.dav_ !== 1'b1) begin
      errors++; $display("FAIL single_ack_dav: got %b want 1", bus.dav_);
    end
    repeat (6) tick();
    read_status(1'b1, st);
    checks++;
    if (st !== 8'h03) begin
      errors++; $display("FAIL single_status: got %02h want 03", st);
    end
    checks++;
    if (seen.size() != 1 || seen[0] !== 8'hA5) begin
      errors++; $display("FAIL single_delivered: got %0d bytes want 1 byte A5", seen.size());
    end
  endtask

  task automatic test_held_strobe();
    logic [7:0] st;
    cons_auto = 1'b1; c_wait = 1'b0; c_low = 0; seen.delete();
    bus.s_ = 1'b0; bus.a0 = 1'b0; bus.iow_ = 1'b0; tb_data = 8'h3C; tb_drive = 1'b1;
    repeat (5) tick();
    bus.s_ = 1'b1; bus.iow_ = 1'b1; tb_drive = 1'b0;
    read_status(1'b1, st);
    checks++;
    if (st !== 8'h01) begin
      errors++; $display("FAIL held_status_busy: got %02h want 01", st);
    end
    repeat (12) tick();
    checks++;
    if (seen.size() != 1 || seen[0] !== 8'h3C) begin
      errors++; $display("FAIL held_one_transfer: got %0d transfers want 1 of 3C", seen.size());
    end
    read_status(1'b1, st);
    checks++;
    if (st !== 8'h03) begin
      errors++; $display("FAIL held_status_idle: got %02h want 03", st);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] st;
    cons_auto = 1'b0; bus.rfd = 1'b0; seen.delete();
    for (int i = 1; i <= 5; i++) write_byte(8'(i));
    checks++;
    if (bus.dav_ !== 1'b1) begin
      errors++; $display("FAIL ovf_blocked_dav: got %b want 1", bus.dav_);
    end
    read_status(1'b1, st);
    checks++;
    if (st !== 8'h04) begin
      errors++; $display("FAIL ovf_status: got %02h want 04", st);
    end
    read_status(1'b1, st);
    checks++;
    if (st !== 8'h00) begin
      errors++; $display("FAIL ovf_cleared: got %02h want 00", st);
    end
    bus.rfd = 1'b1; cons_auto = 1'b1; c_wait = 1'b0; c_low = 0;
    repeat (60) tick();
    checks++;
    if (seen.size() != 4) begin
      errors++; $display("FAIL ovf_count: got %0d bytes want 4", seen.size());
    end
    for (int i = 0; i < 4 && i < seen.size(); i++) begin
      checks++;
      if (seen[i] !== 8'(i + 1)) begin
        errors++; $display("FAIL ovf_order[%0d]: got %02h want %02h", i, seen[i], 8'(i + 1));
      end
    end
    read_status(1'b1, st);
    checks++;
    if (st !== 8'h03) begin
      errors++; $display("FAIL ovf_drained: got %02h want 03", st);
    end
  endtask

  task automatic test_pop_collision();
    logic [7:0] st;
    logic [7:0] exp_b[4];
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
    cons_auto = 1'b0; bus.rfd = 1'b1; seen.delete();
    write_byte(8'h11);
    for (int i = 0; i < 10 && bus.dav_ !== 1'b0; i++) tick();
    checks++;
    if (bus.dav_ !== 1'b0) begin
      errors++; $display("FAIL coll_dav_wait: got %b want 0", bus.dav_);
    end
    write_byte(8'h22); write_byte(8'h33); write_byte(8'h44);
    read_status(1'b1, st);
    checks++;
    if (st !== 8'h00) begin
      errors++; $display("FAIL coll_full_status: got %02h want 00", st);
    end
    bus.rfd = 1'b0;
    bus.s_ = 1'b0; bus.a0 = 1'b0; bus.iow_ = 1'b0; tb_data = 8'h55; tb_drive = 1'b1;
    tick();
    checks++;
    if (bus.dav_ !== 1'b1) begin
      errors++; $display("FAIL coll_ack_dav: got %b want 1", bus.dav_);
    end
    bus.s_ = 1'b1; bus.iow_ = 1'b1; tb_drive = 1'b0;
    tick();
    read_status(1'b1, st);
    checks++;
    if (st !== 8'h05) begin
      errors++; $display("FAIL coll_status_ovr: got %02h want 05", st);
    end
    read_status(1'b1, st);
    checks++;
    if (st !== 8'h01) begin
      errors++; $display("FAIL coll_status_cnt3: got %02h want 01", st);
    end
    bus.rfd = 1'b1; cons_auto = 1'b1; c_wait = 1'b0; c_low = 0;
    repeat (60) tick();
    checks++;
    if (seen.size() != 4) begin
      errors++; $display("FAIL coll_count: got %0d bytes want 4", seen.size());
    end
    for (int i = 0; i < 4 && i < seen.size(); i++) begin
      checks++;
      if (seen[i] !== exp_b[i]) begin
        errors++; $display("FAIL coll_order[%0d]: got %02h want %02h", i, seen[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] st;
    cons_auto = 1'b0; bus.rfd = 1'b1;
    write_byte(8'h61);
    for (int i = 0; i < 10 && bus.dav_ !== 1'b0; i++) tick();
    write_byte(8'h62); write_byte(8'h63);
    checks++;
    if (bus.dav_ !== 1'b0) begin
      errors++; $display("FAIL rmid_pre_dav: got %b want 0", bus.dav_);
    end
    reset_ = 1'b0;
    tick();
    checks++;
    if (bus.dav_ !== 1'b1 || bus.byte_out !== 8'h00) begin
      errors++; $display("FAIL rmid_dav: got dav %b byte %02h want 1 00", bus.dav_, bus.byte_out);
    end
    reset_ = 1'b1;
    read_status(1'b1, st);
    checks++;
    if (st !== 8'h03) begin
      errors++; $display("FAIL rmid_status: got %02h want 03", st);
    end
    seen.delete(); cons_auto = 1'b1; c_wait = 1'b0; c_low = 0;
    write_byte(8'h77);
    repeat (20) tick();
    checks++;
    if (seen.size() != 1 || seen[0] !== 8'h77) begin
      errors++; $display("FAIL rmid_after: got %0d bytes want 1 byte 77", seen.size());
    end
  endtask

  task automatic test_random();
    logic [7:0] st, want;
    logic       exp_fo, exp_ovr, exp_busy;
    int unsigned op;
    cons_auto = 1'b0;
    for (int n = 0; n < 300; n++) begin
      bus.rfd = ($urandom_range(0, 3) != 0);
      if (bus.dav_ === 1'b0) begin
        want = (q.size() > 0) ? q[0] : 8'hxx;
        checks++;
        if (q.size() == 0 || bus.byte_out !== want) begin
          errors++; $display("FAIL rand_byte_out: got %02h want %02h (model size %0d)",
                             bus.byte_out, want, q.size());
        end
      end
      op = $urandom_range(0, 9);
      if (op < 5) begin
        write_byte(8'($urandom));
      end else if (op < 8) begin
        exp_fo   = (q.size() != int'(DEPTH));
        exp_ovr  = m_ovr;
        exp_busy = (q.size() > 0);
        read_status(1'b1, st);
        checks++;
        if (st[7:3] !== 5'b0 || st[0] !== exp_fo || st[2] !== exp_ovr ||
            (exp_busy && st[1] !== 1'b0)) begin
          errors++; $display("FAIL rand_status: got %02h want fo=%b ovr=%b busy=%b",
                             st, exp_fo, exp_ovr, exp_busy);
        end
      end else if (op == 8) begin
        read_status(1'b0, st);
        checks++;
        if (st !== 8'h00) begin
          errors++; $display("FAIL rand_data_read: got %02h want 00", st);
        end
      end else begin
        tick();
      end
    end
    bus.rfd = 1'b1; cons_auto = 1'b1; c_wait = 1'b0; c_low = 0;
    repeat (100) tick();
    checks++;
    if (q.size() != 0) begin
      errors++; $display("FAIL rand_drain: got %0d bytes undelivered want 0", q.size());
    end
    read_status(1'b1, st);
    checks++;
    if (st !== {5'b0, m_ovr, 2'b11}) begin
      errors++; $display("FAIL rand_final_status: got %02h want %02h", st, {5'b0, m_ovr, 2'b11});
    end
  endtask

  initial begin
    reset_   = 1'b0;
    bus.s_   = 1'b1;
    bus.ior_ = 1'b1;
    bus.iow_ = 1'b1;
    bus.a0   = 1'b0;
    bus.rfd  = 1'b1;
    tb_drive = 1'b0;
    tb_data  = 8'h00;
    test_reset();
    test_single_transfer();
    test_held_strobe();
    test_overflow();
    test_pop_collision();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
